// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared FSM state type and constants for the Wishbone timeout bridge.
package wb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam int CNT_W = 8;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: per-request wait counter; expired flags the last cycle a downstream ack may arrive.
module wb_timeout_ctr
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge wb_clk_i) cnt_q <= !wb_rst_n ? '0 : cnt_d;
  assign expired = (cnt_q == LAST);
endmodule

// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: registered Wishbone bridge that aborts a silent downstream cycle after TIMEOUT clocks
// and acknowledges upstream with ERR_DATA plus sticky/irq/count status.
module wb_timeout_bridge
  import wb_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [7:0]  tmo_cnt_o,
  output logic        irq_o
);
  state_e           state_q, state_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [3:0]       m_sel_q, m_sel_d;
  logic [31:0]      m_adr_q, m_adr_d;
  logic [31:0]      m_dat_q, m_dat_d;
  logic             wbs_ack_q, wbs_ack_d;
  logic [31:0]      wbs_dat_q, wbs_dat_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             expired, start, acked, timeout;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .wb_clk_i(wb_clk_i),
    .wb_rst_n(wb_rst_n),
    .clr     (state_q != REQ),
    .en      (state_q == REQ),
    .expired (expired)
  );

  // An upstream abort outranks the ack, and the ack outranks the timeout on the threshold cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    acked   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        start   = wbs_cyc_i && wbs_stb_i;
        state_d = start ? REQ : IDLE;
      end
      REQ: begin
        acked   = wbs_cyc_i && m_ack_i;
        timeout = wbs_cyc_i && !m_ack_i && expired;
        state_d = !wbs_cyc_i ? IDLE : (acked || timeout) ? RESP : REQ;
      end
      default: state_d = IDLE;
    endcase
    m_req_d   = (state_d == REQ);
    m_we_d    = start ? wbs_we_i  : m_req_d && m_we_q;
    m_sel_d   = start ? wbs_sel_i : (m_req_d ? m_sel_q : '0);
    m_adr_d   = start ? wbs_adr_i : (m_req_d ? m_adr_q : '0);
    m_dat_d   = start ? wbs_dat_i : (m_req_d ? m_dat_q : '0);
    wbs_ack_d = (state_d == RESP);
    wbs_dat_d = timeout ? ERR_DATA : acked ? m_dat_i : wbs_dat_q;
    err_d     = timeout || (err_q && !err_clr_i);
    irq_d     = timeout;
    tmo_cnt_d = timeout ? sat_inc(tmo_cnt_q) : tmo_cnt_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_sel_q   <= '0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      wbs_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_sel_q   <= m_sel_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      wbs_ack_q <= wbs_ack_d;
      wbs_dat_q <= wbs_dat_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign m_cyc_o   = m_req_q;
  assign m_stb_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_sel_o   = m_sel_q;
  assign m_adr_o   = m_adr_q;
  assign m_dat_o   = m_dat_q;
  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_dat_q;
  assign err_o     = err_q;
  assign irq_o     = irq_q;
  assign tmo_cnt_o = tmo_cnt_q;
endmodule

// File: tb/tb_wb_timeout_bridge.sv
// tb_wb_timeout_bridge: randomized and directed transactions against a per-transaction outcome model.
module tb_wb_timeout_bridge;
  localparam int TMO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int NONE = 99;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;
  logic        err_clr_i, err_o, irq_o;
  logic [7:0]  tmo_cnt_o;
  int          n_vec = 0, n_bad = 0;
  logic        err_exp = 1'b0;
  int          cnt_exp = 0;
  logic [31:0] dat_exp = '0;

  always #5 clk = ~clk;

  wb_timeout_bridge #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_sel_o  (m_sel_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_ack_i  (m_ack_i),
    .m_dat_i  (m_dat_i),
    .err_clr_i(err_clr_i),
    .err_o    (err_o),
    .tmo_cnt_o(tmo_cnt_o),
    .irq_o    (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m_cyc"}, m_cyc_o, 0);
    chk({tag, " m_stb"}, m_stb_o, 0);
    chk({tag, " m_we"}, m_we_o, 0);
    chk({tag, " m_sel"}, m_sel_o, 0);
    chk({tag, " m_adr"}, m_adr_o, 0);
    chk({tag, " m_dat"}, m_dat_o, 0);
    chk({tag, " ack"}, wbs_ack_o, 0);
    chk({tag, " wbs_dat"}, wbs_dat_o, 0);
    chk({tag, " err"}, err_o, 0);
    chk({tag, " irq"}, irq_o, 0);
    chk({tag, " tmo_cnt"}, tmo_cnt_o, 0);
  endtask

  // d: REQ-cycle index where the ack arrives, a: index where cyc drops, c: index of an err_clr pulse.
  task automatic txn(input logic we, input int d, input int a, input int c, input logic [31:0] rdat);
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    int          kind, len;
    adr  = $urandom;
    wdat = $urandom;
    sel  = 4'($urandom);
    kind = (a < d && a <= TMO - 1) ? 2 : (d <= TMO - 1) ? 0 : 1;
    len  = (kind == 2) ? a + 1 : (kind == 0) ? d + 1 : TMO;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_adr_i = adr;
    wbs_dat_i = wdat;
    step;
    chk("req adr", m_adr_o, adr);
    chk("req dat", m_dat_o, wdat);
    chk("req sel", m_sel_o, sel);
    chk("req we", m_we_o, we);
    chk("req stb", m_stb_o, 1);
    wbs_stb_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk("req cyc held", m_cyc_o, 1);
      chk("no early ack", wbs_ack_o, 0);
      m_ack_i   = (i == d);
      m_dat_i   = (i == d) ? rdat : $urandom;
      wbs_cyc_i = (i != a);
      err_clr_i = (i == c);
      step;
    end
    m_ack_i   = 1'b0;
    err_clr_i = 1'b0;
    err_exp   = (kind == 1) || (err_exp && !(c < len));
    if (kind == 1 && cnt_exp < 255) cnt_exp++;
    if (kind == 0) dat_exp = rdat;
    if (kind == 1) dat_exp = ERR;
    chk("cyc dropped", m_cyc_o, 0);
    chk("stb dropped", m_stb_o, 0);
    chk("adr cleared", m_adr_o, 0);
    chk("ack pulse", wbs_ack_o, kind != 2);
    chk("irq pulse", irq_o, kind == 1);
    chk("err flag", err_o, err_exp);
    chk("tmo count", tmo_cnt_o, cnt_exp);
    if (kind != 2) chk("rd data", wbs_dat_o, dat_exp);
    wbs_cyc_i = 1'b0;
    step;
    chk("ack one cycle", wbs_ack_o, 0);
    chk("irq one cycle", irq_o, 0);
  endtask

  initial begin
    int d, a, c;
    rst_n = 1'b0;
    {wbs_cyc_i, wbs_stb_i, wbs_we_i, m_ack_i, err_clr_i} = '0;
    {wbs_sel_i, wbs_adr_i, wbs_dat_i, m_dat_i} = '0;
    step;
    step;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step;
    txn(1'b0, 3, NONE, NONE, 32'h12345678);
    txn(1'b1, NONE, NONE, NONE, $urandom);
    txn(1'b0, TMO - 1, NONE, NONE, 32'hCAFEF00D);
    txn(1'b0, NONE, 2, NONE, $urandom);
    txn(1'b0, 0, NONE, 0, 32'h0BADF00D);
    for (int t = 0; t < 60; t++) begin
      d = $urandom_range(0, 6);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : NONE;
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : NONE;
      if (a == d) a = NONE;
      txn(1'($urandom_range(0, 1)), d, a, c, $urandom);
    end
    for (int t = 0; t < 259; t++) txn(1'($urandom_range(0, 1)), NONE, NONE, NONE, $urandom);
    txn(1'b1, NONE, NONE, TMO - 1, $urandom);
    chk("sat count", tmo_cnt_o, 255);
    chk("set wins clr", err_o, 1);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = 32'h00000040;
    wbs_dat_i = 32'h55AA55AA;
    step;
    wbs_stb_i = 1'b0;
    step;
    rst_n = 1'b0;
    step;
    chk_all_zero("mid reset");
    rst_n     = 1'b1;
    wbs_cyc_i = 1'b0;
    err_exp   = 1'b0;
    cnt_exp   = 0;
    dat_exp   = '0;
    step;
    txn(1'b0, 1, NONE, NONE, 32'h600DD00D);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_timeout_bridge.md
WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: downstream cycles allowed before abort; legal range 2..255.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_n  in  1  reset, synchronous, active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone request from the management core.
REQ-006 wbs_sel_i  in  4; wbs_adr_i, wbs_dat_i  in  32 each  upstream select, address and write data.
REQ-007 wbs_ack_o  out  1; wbs_dat_o  out  32  upstream acknowledge and read data, both registered.
REQ-008 m_cyc_o, m_stb_o, m_we_o  out  1 each; m_sel_o  out  4; m_adr_o, m_dat_o  out  32 each  registered downstream request to the peripheral decoder.
REQ-009 m_ack_i  in  1; m_dat_i  in  32  downstream acknowledge and read data.
REQ-010 err_clr_i  in  1  clears the sticky error flag.
REQ-011 err_o  out  1  sticky timeout flag.
REQ-012 tmo_cnt_o  out  8  saturating count of timeouts.
REQ-013 irq_o  out  1  one-cycle pulse per timeout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-015 In IDLE, when wbs_cyc_i and wbs_stb_i are both 1, the block SHALL latch adr, dat, sel and we, clear the wait counter, and enter REQ.
REQ-016 In REQ, m_cyc_o and m_stb_o SHALL be 1 and the m_* buses SHALL carry the latched values; in every other state they SHALL be 0.
REQ-017 In REQ, on m_ack_i=1 the block SHALL latch m_dat_i into wbs_dat_o and enter RESP; m_cyc_o and m_stb_o SHALL drop the next cycle.
REQ-018 In REQ, the wait counter SHALL increment once per cycle.
REQ-019 If the wait counter reaches TIMEOUT-1 with m_ack_i=0, the block SHALL drop the downstream strobe, load ERR_DATA into wbs_dat_o, set err_o, pulse irq_o, increment tmo_cnt_o (saturating at 255), and enter RESP.
REQ-020 If m_ack_i=1 in the same cycle the timeout threshold is reached, the ack SHALL win and no error SHALL be recorded.
REQ-021 In RESP, wbs_ack_o SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-022 A write that times out SHALL still be acknowledged; only the status outputs reveal the timeout.
REQ-023 Latency: the request is sampled at edge 0, m_stb_o rises after edge 0, m_ack_i is sampled at edge k, and wbs_ack_o is high for the cycle after edge k. Minimum request-to-ack is 2 cycles.
REQ-024 Abort: if wbs_cyc_i drops while in REQ, the block SHALL drop the downstream request next cycle, return to IDLE, and assert no ack, error or irq.
REQ-025 A new request SHALL NOT be captured in the RESP cycle; back-to-back requests SHALL be spaced at least one IDLE cycle apart.
REQ-026 If err_clr_i and a new timeout occur in the same cycle, err_o SHALL remain 1 (set wins).
REQ-027 err_clr_i SHALL NOT affect tmo_cnt_o.

Reset
REQ-028 With wb_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and all outputs, including all data buses, SHALL be 0 the next cycle.
REQ-029 Reset mid-transaction SHALL abort silently: no ack and no error.

Structure
REQ-030 Package wb_bridge_pkg SHALL hold the state enum, the default ERR_DATA value, and the counter width constant (8).
REQ-031 The wait counter with its threshold compare SHALL be a sub-module named wb_timeout_ctr, with inputs clr and en and output expired.

Verification
REQ-032 Read with downstream ack 3 cycles after m_stb_o rises, m_dat_i=32'h12345678 -> wbs_ack_o pulses once, wbs_dat_o=32'h12345678, err_o=0.
REQ-033 Write with TIMEOUT=4 and no downstream ack -> m_stb_o drops after 4 cycles; wbs_ack_o pulses once with wbs_dat_o=32'hDEADBEEF; err_o=1, irq_o pulses one cycle, tmo_cnt_o=1.
REQ-034 TIMEOUT=4 with m_ack_i arriving exactly on the threshold cycle -> normal ack, err_o stays 0, tmo_cnt_o unchanged.
REQ-035 wbs_cyc_i dropped 2 cycles into REQ -> m_cyc_o=0 next cycle, no wbs_ack_o, no irq_o.
REQ-036 260 consecutive timeouts -> tmo_cnt_o saturates at 255; err_clr_i asserted in the same cycle as a timeout leaves err_o=1.
REQ-037 wb_rst_n=0 during REQ -> all outputs 0 next cycle; a subsequent read completes normally.
